mano_computer: RTL and testbench
================================

# mano_computer

Mano-style basic computer: a 16-bit accumulator CPU (`cpu`) wired to a single-port word-addressed memory (`sram`) that holds both program and data. After reset it fetches from address 0 and runs until it executes `HLT`. Benches preload memory by writing the `mem` array of the `sram` instance directly: program at 0, data blocks at 100 and 200, result word at 300.

## Interface
- `DATA_WIDTH`, 16: word width; fixed at 16.
- `ADDR_WIDTH`, 16: memory bus width; instruction address field is 12 bits, zero-extended.
- `MEM_DEPTH`, 4096: words in `sram.mem`, indexed 0..MEM_DEPTH-1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: one clock; reset is synchronous and active-high. Asserted when `reset_n`=1, despite the suffix.
- `halted` out 1: 1 once `HLT` has executed.
- `pc` out 12: program counter, for debug.
- `ac` out 16: accumulator, for debug.
- Internal bus, `cpu`↔`sram`: `addr`[15:0], `data_out` (cpu→mem), `data_in` (mem→cpu), `we_n` (active-low write).

## Operation
- **Registers:** AR(12), PC(12), DR(16), AC(16), IR(16), I(1), E(1), SC(3, states T0..T6), S (run flag).
- **Reset:** PC, AR, DR, AC, IR, I, E and SC all clear to 0; S=1; `halted`=0; `we_n`=1. Memory contents are not cleared.
- **Memory:** asynchronous read, `data_in` = `mem[addr]` in the same cycle. Synchronous write at the edge when `we_n`=0. `addr` is always {4'b0, AR}.
- **Instruction format:** bit 15 = I, bits 14:12 = opcode, bits 11:0 = address.
- **Fetch/decode (every instruction):**
  - T0: AR←PC.
  - T1: IR←M[AR], PC←PC+1.
  - T2: AR←IR[11:0], I←IR[15].
- **Memory-reference opcodes 0–6:** at T3, AR←M[AR] if I=1, otherwise idle.
  - AND (0): T4 DR←M; T5 AC←AC&DR.
  - ADD (1): T4 DR←M; T5 {E,AC}←AC+DR (E = carry out).
  - LDA (2): T4 DR←M; T5 AC←DR.
  - STA (3): T4 M[AR]←AC.
  - BUN (4): T4 PC←AR.
  - BSA (5): T4 M[AR]←PC, AR←AR+1; T5 PC←AR.
  - ISZ (6): T4 DR←M; T5 DR←DR+1; T6 M[AR]←DR, and PC←PC+1 if DR==0.
  - The last listed step of each instruction also clears SC.
- **Register-reference (opcode 7, I=0):** executes at T3, then SC←0. Multiple bits in one word all apply in that same cycle; skips use the pre-update values.
  - Bit 11 CLA, bit 10 CLE, bit 9 CMA, bit 8 CME.
  - Bit 7 CIR: {AC,E}←{E,AC} rotated right. Bit 6 CIL: rotate left through E.
  - Bit 5 INC: AC←AC+1 (E unchanged).
  - Skips: bit 4 SPA (AC[15]=0), bit 3 SNA (AC[15]=1), bit 2 SZA (AC=0), bit 1 SZE (E=0).
  - Bit 0 HLT: S←0.
- **I/O class (opcode 7, I=1):** no-op; SC←0 at T3.
- **Arithmetic:** all modulo 2^16; PC and AR wrap modulo 2^12 (PC 4095+1 → 0).
- **Halt:** while S=0, no register or memory changes, `we_n`=1, `halted`=1. Only reset leaves this state.

## Timing
- **Cycles per instruction:** AND, ADD, LDA, BSA = 6; STA, BUN = 5; ISZ = 7; register-reference and I/O = 4. Indirect addressing adds no cycles, because T3 is always spent.
- **`we_n`:** low for exactly one cycle (STA T4, BSA T4, ISZ T6); `data_out` is valid in that same cycle.
- **Reset mid-instruction:** at the next edge the CPU returns to T0 with PC=0 and no write is performed. A partially executed ISZ or BSA leaves memory in whatever state it had before that edge.
- **Outputs:** `halted`, `pc` and `ac` are registered values, updated at the same edge as their sources.

## Test plan
- **Add and store:** code 0:2064 (LDA 100), 1:1065 (ADD 101), 2:312C (STA 300), 3:7001 (HLT); mem[100]=5, mem[101]=7. Expect mem[300]=12, `halted`=1 at cycle 21 after reset, PC=4.
- **Indirect load with overflow carry:** LDA I 10 with mem[10]=200, mem[200]=FFFF, then INC, CME, then STA 300. Expect mem[300]=0000, E=1.
- **ISZ loop summing 5 scores:** count word -5 and pointer 100, summing mem[100..104]. Expect mem[300] = the sum, and the loop exits exactly when the count reaches 0.
- **BSA subroutine:** BSA 50 at address 7. Expect mem[50]=8, execution continues at 51, and a BUN I 50 return resumes at 8.
- **Register-reference combos and skips:** CLA+CMA in one word gives AC=FFFF. SNA skips; SZA does not. CIL with E=1 and AC=8000 gives AC=0001, E=1.
- **Reset mid-operation:** assert reset for 1 cycle at T4 of STA. Expect no write to mem[300], PC=0, AC=0, and the program re-runs to the same result.

Source files
------------

// File: rtl/mano_computer.sv
// Mano basic computer: 16-bit accumulator CPU wired to a word-addressed memory
// that holds both program and data. Runs from address 0 after reset until HLT.

module mano_sram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MEM_DEPTH  = 4096
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_we_n,
  output logic [DATA_WIDTH-1:0] o_data
);
  localparam int unsigned IdxW = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [IdxW-1:0]       w_idx;
  logic                  w_unused_addr;

  assign w_idx         = i_addr[IdxW-1:0];
  // Upper address bits are always zero from the CPU.
  assign w_unused_addr = ^i_addr[ADDR_WIDTH-1:IdxW];
  assign o_data        = mem[w_idx];

  // Synchronous write; contents survive reset.
  always_ff @(posedge clk) begin
    if (!i_we_n) mem[w_idx] <= i_data;
  end
endmodule

module mano_cpu #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_we_n,
  output logic                  o_halted,
  output logic [11:0]           o_pc,
  output logic [DATA_WIDTH-1:0] o_ac
);
  typedef enum logic [2:0] {StT0, StT1, StT2, StT3, StT4, StT5, StT6} sc_e;

  localparam logic [2:0] OpAnd = 3'd0, OpAdd = 3'd1, OpLda = 3'd2, OpSta = 3'd3;
  localparam logic [2:0] OpBun = 3'd4, OpBsa = 3'd5, OpIsz = 3'd6, OpReg = 3'd7;

  logic [11:0]           r_ar, r_pc, w_ar_d, w_pc_d;
  logic [DATA_WIDTH-1:0] r_dr, r_ac, r_ir, w_dr_d, w_ac_d, w_ir_d;
  logic                  r_i, r_e, r_s, w_i_d, w_e_d, w_s_d;
  sc_e                   r_sc, w_sc_d;
  logic                  w_we_n;
  logic [DATA_WIDTH-1:0] w_data_out, w_rr_ac;
  logic                  w_rr_e, w_skip;
  logic [DATA_WIDTH:0]   w_sum;
  logic [2:0]            w_op;

  assign w_op     = r_ir[14:12];
  assign w_sum    = {1'b0, r_ac} + {1'b0, r_dr};
  assign o_addr   = {{(ADDR_WIDTH-12){1'b0}}, r_ar};
  assign o_data   = w_data_out;
  assign o_we_n   = w_we_n;
  assign o_halted = ~r_s;
  assign o_pc     = r_pc;
  assign o_ac     = r_ac;

  // Skip test for register-reference words uses pre-update AC and E.
  assign w_skip = (r_ir[4] && !r_ac[15]) || (r_ir[3] && r_ac[15]) ||
                  (r_ir[2] && (r_ac == '0)) || (r_ir[1] && !r_e);

  // Next-state and memory-bus control for the T-state sequencer.
  always_comb begin
    w_ar_d     = r_ar;
    w_pc_d     = r_pc;
    w_dr_d     = r_dr;
    w_ac_d     = r_ac;
    w_ir_d     = r_ir;
    w_i_d      = r_i;
    w_e_d      = r_e;
    w_s_d      = r_s;
    w_sc_d     = r_sc;
    w_we_n     = 1'b1;
    w_data_out = r_ac;
    w_rr_ac    = r_ac;
    w_rr_e     = r_e;
    if (r_s) begin
      unique case (r_sc)
        StT0: begin
          w_ar_d = r_pc;
          w_sc_d = StT1;
        end
        StT1: begin
          w_ir_d = i_data;
          w_pc_d = r_pc + 12'd1;
          w_sc_d = StT2;
        end
        StT2: begin
          w_ar_d = r_ir[11:0];
          w_i_d  = r_ir[15];
          w_sc_d = StT3;
        end
        StT3: begin
          if (w_op != OpReg) begin
            if (r_i) w_ar_d = i_data[11:0];
            w_sc_d = StT4;
          end else begin
            w_sc_d = StT0;
            if (!r_i) begin
              // Bits apply in this order within one word: CLA, CLE, CMA, CME, CIR, CIL, INC.
              if (r_ir[11]) w_rr_ac = '0;
              if (r_ir[10]) w_rr_e = 1'b0;
              if (r_ir[9]) w_rr_ac = ~w_rr_ac;
              if (r_ir[8]) w_rr_e = ~w_rr_e;
              if (r_ir[7]) {w_rr_ac, w_rr_e} = {w_rr_e, w_rr_ac};
              if (r_ir[6]) {w_rr_e, w_rr_ac} = {w_rr_ac, w_rr_e};
              if (r_ir[5]) w_rr_ac = w_rr_ac + DATA_WIDTH'(1);
              if (w_skip) w_pc_d = r_pc + 12'd1;
              if (r_ir[0]) w_s_d = 1'b0;
              w_ac_d = w_rr_ac;
              w_e_d  = w_rr_e;
            end
          end
        end
        StT4: begin
          w_sc_d = StT5;
          unique case (w_op)
            OpAnd, OpAdd, OpLda, OpIsz: w_dr_d = i_data;
            OpSta: begin
              w_we_n = 1'b0;
              w_sc_d = StT0;
            end
            OpBun: begin
              w_pc_d = r_ar;
              w_sc_d = StT0;
            end
            OpBsa: begin
              w_we_n     = 1'b0;
              w_data_out = {{(DATA_WIDTH-12){1'b0}}, r_pc};
              w_ar_d     = r_ar + 12'd1;
            end
            default: w_sc_d = StT0;
          endcase
        end
        StT5: begin
          w_sc_d = StT0;
          unique case (w_op)
            OpAnd: w_ac_d = r_ac & r_dr;
            OpAdd: {w_e_d, w_ac_d} = w_sum;
            OpLda: w_ac_d = r_dr;
            OpBsa: w_pc_d = r_ar;
            OpIsz: begin
              w_dr_d = r_dr + DATA_WIDTH'(1);
              w_sc_d = StT6;
            end
            default: w_sc_d = StT0;
          endcase
        end
        StT6: begin
          w_we_n     = 1'b0;
          w_data_out = r_dr;
          if (r_dr == '0) w_pc_d = r_pc + 12'd1;
          w_sc_d = StT0;
        end
        default: w_sc_d = StT0;
      endcase
    end
    // A reset edge must never commit a half-finished write.
    if (i_rst) w_we_n = 1'b1;
  end

  // Architectural registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_ar <= '0;
      r_pc <= '0;
      r_dr <= '0;
      r_ac <= '0;
      r_ir <= '0;
      r_i  <= 1'b0;
      r_e  <= 1'b0;
      r_s  <= 1'b1;
      r_sc <= StT0;
    end else begin
      r_ar <= w_ar_d;
      r_pc <= w_pc_d;
      r_dr <= w_dr_d;
      r_ac <= w_ac_d;
      r_ir <= w_ir_d;
      r_i  <= w_i_d;
      r_e  <= w_e_d;
      r_s  <= w_s_d;
      r_sc <= w_sc_d;
    end
  end
endmodule

module mano_computer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MEM_DEPTH  = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,  // active-high despite the name
  output logic                  halted,
  output logic [11:0]           pc,
  output logic [DATA_WIDTH-1:0] ac
);
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data_out, w_data_in;
  logic                  w_we_n;

  mano_cpu #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_cpu (
    .clk     (clk),
    .i_rst   (reset_n),
    .i_data  (w_data_in),
    .o_addr  (w_addr),
    .o_data  (w_data_out),
    .o_we_n  (w_we_n),
    .o_halted(halted),
    .o_pc    (pc),
    .o_ac    (ac)
  );

  mano_sram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_sram (
    .clk   (clk),
    .i_addr(w_addr),
    .i_data(w_data_out),
    .i_we_n(w_we_n),
    .o_data(w_data_in)
  );
endmodule

// File: tb/tb_mano_computer.sv
// Directed programs for the Mano computer; expected results are queued when a
// program is loaded and popped in order once the machine halts.

module tb_mano_computer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        halted;
  logic [11:0] pc;
  logic [15:0] ac;

  int checks = 0;
  int errors = 0;
  int cyc;
  int sum;
  logic [15:0] score;

  string       tag_q[$];
  logic [15:0] exp_q[$];

  mano_computer dut (
    .clk    (clk),
    .reset_n(reset_n),
    .halted (halted),
    .pc     (pc),
    .ac     (ac)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_v(input string tag, input logic [15:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input logic [15:0] obs);
    string t;
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, obs, e);
    end
  endtask

  // Leaves reset asserted, parked on a falling edge.
  task automatic hold_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) dut.u_sram.mem[i] = 16'h0000;
  endtask

  task automatic ld(input int a, input logic [15:0] w);
    dut.u_sram.mem[a] = w;
  endtask

  task automatic run_to_halt(input int max, output int n);
    n = 0;
    while (halted !== 1'b1 && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    // ---- Add and store ----
    hold_reset();
    clear_mem();
    check("reset_pc", {4'h0, pc}, 16'h0000);
    check("reset_ac", ac, 16'h0000);
    check("reset_halted", {15'h0, halted}, 16'h0000);
    ld(0, 16'h2064); ld(1, 16'h1065); ld(2, 16'h312C); ld(3, 16'h7001);
    ld(100, 16'd5); ld(101, 16'd7);
    expect_v("add_cycles", 16'd21);
    expect_v("add_mem300", 16'h000C);
    expect_v("add_pc", 16'h0004);
    expect_v("add_ac", 16'h000C);
    reset_n = 1'b0;
    run_to_halt(500, cyc);
    pop_check(16'(cyc));
    pop_check(dut.u_sram.mem[300]);
    pop_check({4'h0, pc});
    pop_check(ac);
    // Halted machine must stay frozen.
    expect_v("frozen_pc", 16'h0004);
    expect_v("frozen_halted", 16'h0001);
    repeat (5) @(posedge clk);
    #1;
    pop_check({4'h0, pc});
    pop_check({15'h0, halted});

    // ---- Indirect load with carry, then CME and CIL ----
    hold_reset();
    clear_mem();
    ld(0, 16'hA00A); ld(1, 16'h7020); ld(2, 16'h7100); ld(3, 16'h312C);
    ld(4, 16'h7040); ld(5, 16'h312D); ld(6, 16'h7001);
    ld(10, 16'd200); ld(200, 16'hFFFF); ld(300, 16'h1234);
    expect_v("ind_cycles", 16'd32);
    expect_v("ind_mem300", 16'h0000);
    expect_v("ind_mem301_e", 16'h0001);
    expect_v("ind_pc", 16'h0007);
    reset_n = 1'b0;
    run_to_halt(500, cyc);
    pop_check(16'(cyc));
    pop_check(dut.u_sram.mem[300]);
    pop_check(dut.u_sram.mem[301]);
    pop_check({4'h0, pc});

    // ---- ISZ loop summing five scores ----
    hold_reset();
    clear_mem();
    ld(0, 16'h7800); ld(1, 16'h9014); ld(2, 16'h6014); ld(3, 16'h6015);
    ld(4, 16'h4001); ld(5, 16'h312C); ld(6, 16'h7001);
    ld(20, 16'd100); ld(21, 16'hFFFB);
    sum = 0;
    for (int k = 0; k < 5; k++) begin
      score = 16'($urandom_range(0, 1000));
      ld(100 + k, score);
      sum += int'(score);
    end
    // CLA 4 + 4 looping passes of 25 + final pass 20 + STA 5 + HLT 4.
    expect_v("isz_cycles", 16'd133);
    expect_v("isz_sum", 16'(sum));
    expect_v("isz_count", 16'h0000);
    expect_v("isz_ptr", 16'd105);
    expect_v("isz_pc", 16'h0007);
    reset_n = 1'b0;
    run_to_halt(1000, cyc);
    pop_check(16'(cyc));
    pop_check(dut.u_sram.mem[300]);
    pop_check(dut.u_sram.mem[21]);
    pop_check(dut.u_sram.mem[20]);
    pop_check({4'h0, pc});

    // ---- BSA subroutine and indirect return ----
    hold_reset();
    clear_mem();
    ld(0, 16'h7800);
    for (int a = 1; a <= 6; a++) ld(a, 16'h7020);
    ld(7, 16'h5032); ld(8, 16'h312C); ld(9, 16'h7001);
    ld(51, 16'h7020); ld(52, 16'hC032);
    expect_v("bsa_cycles", 16'd52);
    expect_v("bsa_mem50", 16'h0008);
    expect_v("bsa_mem300", 16'h0007);
    expect_v("bsa_pc", 16'h000A);
    reset_n = 1'b0;
    run_to_halt(500, cyc);
    pop_check(16'(cyc));
    pop_check(dut.u_sram.mem[50]);
    pop_check(dut.u_sram.mem[300]);
    pop_check({4'h0, pc});

    // ---- Register-reference combinations and skips ----
    hold_reset();
    clear_mem();
    ld(0, 16'h7A00); ld(1, 16'h312C); ld(2, 16'h7008); ld(3, 16'h7001);
    ld(4, 16'h7004); ld(5, 16'h7500); ld(6, 16'h2064); ld(7, 16'h7040);
    ld(8, 16'h312D); ld(9, 16'h7002); ld(10, 16'h7040); ld(11, 16'h312E);
    ld(12, 16'h7001); ld(100, 16'h8000);
    expect_v("rr_cycles", 16'd53);
    expect_v("rr_cla_cma", 16'hFFFF);
    expect_v("rr_cil_e1", 16'h0001);
    expect_v("rr_sze_noskip", 16'h0003);
    expect_v("rr_pc", 16'h000D);
    reset_n = 1'b0;
    run_to_halt(500, cyc);
    pop_check(16'(cyc));
    pop_check(dut.u_sram.mem[300]);
    pop_check(dut.u_sram.mem[301]);
    pop_check(dut.u_sram.mem[302]);
    pop_check({4'h0, pc});

    // ---- Reset during STA T4 ----
    hold_reset();
    clear_mem();
    ld(0, 16'h2064); ld(1, 16'h1065); ld(2, 16'h312C); ld(3, 16'h7001);
    ld(100, 16'd5); ld(101, 16'd7); ld(300, 16'hDEAD);
    expect_v("rst_mid_mem300", 16'hDEAD);
    expect_v("rst_mid_pc", 16'h0000);
    expect_v("rst_mid_ac", 16'h0000);
    reset_n = 1'b0;
    // Edges 1-12 run LDA and ADD, 13-16 are STA T0..T3; next edge is the write.
    repeat (16) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    pop_check(dut.u_sram.mem[300]);
    pop_check({4'h0, pc});
    pop_check(ac);
    expect_v("rst_rerun_cycles", 16'd21);
    expect_v("rst_rerun_mem300", 16'h000C);
    reset_n = 1'b0;
    run_to_halt(500, cyc);
    pop_check(16'(cyc));
    pop_check(dut.u_sram.mem[300]);

    check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
